rf_wb_queue: RTL and testbench

Write-back queue that owns the write port of the single-cycle out-of-order core's register file. It accepts completed results (destination register plus value) through a valid/ready handshake, buffers them in order in a small FIFO, and drains one entry per cycle onto the register file's `wen`/`rd`/`rd_data` port. Draining is gated by `drain_en`. Optional forwarding ports let the issue stage read queued-but-unwritten values so that read-after-write stays correct while results wait in the queue.

---
 rtl/rf_wb_queue.sv | 120 ++++++++++++
 tb/tb_rf_wb_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order write-back queue that owns the register-file write port.
// Latency: a result pushed at edge t reaches wen/rd/rd_data in cycle t+1 at the earliest (no cut-through).
// Backpressure: in_ready = !full, independent of in_valid and not raised by a same-cycle pop; drain gated by drain_en.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        result handshake; in_rd/in_data carry destination and value
//   drain_en                 register-file write port available this cycle
//   wen/rd/rd_data           register-file write port, driven from the head entry
//   fwd_rs1/2 -> fwd_hit1/2, fwd_data1/2   lookup of the youngest queued write per register
//   count                    current occupancy, 0..DEPTH
//
// Build option: define WB_FWD_EN to build the forwarding search; without it the
// fwd_* outputs are tied to 0 and the issue stage must stall on queued destinations.
module rf_wb_queue #(
  parameter int DEPTH       = 4,
  parameter int DEPTH_LOG   = 2,
  parameter int RF_SIZE_LOG = 5,
  parameter int REG_LEN     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RF_SIZE_LOG-1:0] in_rd,
  input  logic [REG_LEN-1:0]     in_data,
  input  logic                   drain_en,
  output logic                   wen,
  output logic [RF_SIZE_LOG-1:0] rd,
  output logic [REG_LEN-1:0]     rd_data,
  input  logic [RF_SIZE_LOG-1:0] fwd_rs1,
  input  logic [RF_SIZE_LOG-1:0] fwd_rs2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [REG_LEN-1:0]     fwd_data1,
  output logic [REG_LEN-1:0]     fwd_data2,
  output logic [DEPTH_LOG:0]     count
);

  typedef struct packed {
    logic [RF_SIZE_LOG-1:0] rd;
    logic [REG_LEN-1:0]     data;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  logic [DEPTH_LOG-1:0]   head_q, head_d;
  logic [DEPTH_LOG-1:0]   tail_q, tail_d;
  logic [DEPTH_LOG:0]     count_q, count_d;

  logic empty, full, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wen      = !empty && drain_en;
  assign pop      = wen;
  assign rd       = mem_q[head_q].rd;
  assign rd_data  = mem_q[head_q].data;
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + DEPTH_LOG'(1);
    if (pop)  head_d = head_q + DEPTH_LOG'(1);
    if (push && !pop)      count_d = count_q + (DEPTH_LOG+1)'(1);
    else if (!push && pop) count_d = count_q - (DEPTH_LOG+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{rd: in_rd, data: in_data};
  end

`ifdef WB_FWD_EN
  // Walk entries oldest to youngest relative to head so that a later match
  // overrides an earlier one; this keeps age priority correct across wrap.
  // The entry being pushed this cycle is not yet in mem_q, so it stays invisible.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((DEPTH_LOG+1)'(i) < count_q) begin
        if (mem_q[head_q + DEPTH_LOG'(i)].rd == fwd_rs1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_q[head_q + DEPTH_LOG'(i)].data;
        end
        if (mem_q[head_q + DEPTH_LOG'(i)].rd == fwd_rs2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_q[head_q + DEPTH_LOG'(i)].data;
        end
      end
    end
  end
`else
  logic unused_fwd_rs;
  assign unused_fwd_rs = ^{fwd_rs1, fwd_rs2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;
  localparam int DEPTH = 4;
  localparam int DEPTH_LOG = 2;
  localparam int RF_SIZE_LOG = 5;
  localparam int REG_LEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, drain_en, wen;
  logic [RF_SIZE_LOG-1:0] in_rd, rd, fwd_rs1, fwd_rs2;
  logic [REG_LEN-1:0] in_data, rd_data, fwd_data1, fwd_data2;
  logic fwd_hit1, fwd_hit2;
  logic [DEPTH_LOG:0] count;

  rf_wb_queue #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .RF_SIZE_LOG(RF_SIZE_LOG), .REG_LEN(REG_LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .drain_en(drain_en), .wen(wen), .rd(rd), .rd_data(rd_data),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RF_SIZE_LOG-1:0] rd;
    logic [REG_LEN-1:0]     data;
  } ent_t;

  ent_t model_q[$];   // occupancy/content model of the queue
  ent_t exp_q[$];     // scoreboard of expected register-file writes
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference lookup: youngest queued write to the register, else miss with 0.
  function automatic logic [REG_LEN:0] ref_fwd(input logic [RF_SIZE_LOG-1:0] rs);
`ifdef WB_FWD_EN
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].rd == rs) return {1'b1, model_q[i].data};
`endif
    return '0;
  endfunction

  // Monitor: samples at negedge with inputs stable, then advances the model
  // to the state the DUT will hold after the next rising edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      int sz;
      bit exp_wen;
      logic [REG_LEN:0] f1, f2;
      sz = model_q.size();
      exp_wen = (sz > 0) && drain_en;
      check("count", 64'(count), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      check("wen", 64'(wen), 64'(exp_wen));
      if (exp_wen) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 64'(0), 64'(1));
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          check("wr_rd", 64'(rd), 64'(e.rd));
          check("wr_data", 64'(rd_data), 64'(e.data));
        end
      end
      f1 = ref_fwd(fwd_rs1);
      f2 = ref_fwd(fwd_rs2);
      check("fwd_hit1", 64'(fwd_hit1), 64'(f1[REG_LEN]));
      check("fwd_data1", 64'(fwd_data1), 64'(f1[REG_LEN-1:0]));
      check("fwd_hit2", 64'(fwd_hit2), 64'(f2[REG_LEN]));
      check("fwd_data2", 64'(fwd_data2), 64'(f2[REG_LEN-1:0]));
      if (exp_wen) void'(model_q.pop_front());
      if (in_valid && sz < DEPTH) model_q.push_back('{rd: in_rd, data: in_data});
    end
  end

  // Driver: one cycle of stimulus; records the expected write when the offer will be taken.
  task automatic step(input bit v, input logic [RF_SIZE_LOG-1:0] r, input logic [REG_LEN-1:0] d, input bit de);
    @(posedge clk);
    #1;
    in_valid = v;
    in_rd    = r;
    in_data  = d;
    drain_en = de;
    if (v && model_q.size() < DEPTH) exp_q.push_back('{rd: r, data: d});
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; drain_en = 1'b0;
    fwd_rs1 = '0; fwd_rs2 = '0;
    #2;
    check("rst_count", 64'(count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_wen", 64'(wen), 64'(0));
    check("rst_fwd_hit1", 64'(fwd_hit1), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single push with drain enabled: write appears the next cycle.
    step(1'b1, 5'd2, 32'h5, 1'b1);
    drain_all("t1_drained");

    // Fill with drain held off, fifth offer held off, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 1), 32'h10 + 32'(i), 1'b0);
    step(1'b1, 5'd9, 32'h99, 1'b0);
    step(1'b1, 5'd9, 32'h99, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    drain_all("t2_drained");

    // Two queued writes to r3: forwarding must return the younger one.
    fwd_rs1 = 5'd3; fwd_rs2 = 5'd4;
    step(1'b1, 5'd3, 32'hA, 1'b0);
    step(1'b1, 5'd3, 32'hB, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    drain_all("t3_drained");

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd3 + 5'(i), 32'h30 + 32'(i), 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'(3));
    mon_en = 1'b0;
    drain_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wen", 64'(wen), 64'(0));
    check("async_rst_count", 64'(count), 64'(0));
    check("async_rst_fwd_hit1", 64'(fwd_hit1), 64'(0));
    model_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);

    // Wrap: two r5 entries land at indices 3 and 0.
    fwd_rs1 = 5'd5; fwd_rs2 = 5'd6;
    step(1'b1, 5'd1, 32'h41, 1'b0);
    step(1'b1, 5'd2, 32'h42, 1'b0);
    step(1'b1, 5'd3, 32'h43, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 5'd5, 32'h55, 1'b0);
    step(1'b1, 5'd5, 32'h66, 1'b0);
    step(1'b1, 5'd6, 32'h77, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    drain_all("wrap_drained");

    // Randomized traffic with alternating drain pressure.
    for (int i = 0; i < 1500; i++) begin
      bit de;
      if ((i / 100) % 2 == 0) de = ($urandom_range(0, 3) != 0);
      else                    de = ($urandom_range(0, 3) == 0);
      fwd_rs1 = 5'($urandom_range(0, 7));
      fwd_rs2 = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom), de);
    end
    drain_all("rand_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
